// File: rtl/bus_arbiter_2to1_pkg.sv
// bus_arbiter_2to1_pkg
//   Shared definitions for the two-requester memory-port arbiter:
//   FSM state encoding, default access latency, counter width and the
//   round-robin winner selection used on the IDLE->ACCESS edge.
package bus_arbiter_2to1_pkg;

  // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_LAT = 2;
  localparam int CNT_W       = 4;

  // Winner of an arbitration round. A lone requester always wins.
  // On a tie the requester that did NOT own the last completed access
  // wins, which gives strict alternation under continuous contention.
  function automatic logic arb_winner(input logic req0,
                                      input logic req1,
                                      input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

endpackage

// File: rtl/bus_arbiter_2to1_mux.sv
// MUX_2to1
//   Plain two-input selector used to route requester signals onto the
//   shared memory port.
//   Ports:
//     sel  in   1     0 selects in0, 1 selects in1
//     in0  in   size  input for requester 0
//     in1  in   size  input for requester 1
//     out  out  size  selected value (combinational)
module MUX_2to1 #(
  parameter int size = 32
) (
  input  logic            sel,
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  output logic [size-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1
//   Arbitrates two requesters onto one memory port. Requests are sampled
//   only in IDLE; the winner owns the port for exactly LAT ACCESS cycles,
//   read data is captured in the final ACCESS cycle, and a one-cycle DONE
//   state pulses the owner's done output. Ties are resolved round-robin.
//   Ports:
//     clk_i        in   1     clock, rising edge
//     rst_i        in   1     asynchronous reset, active-high
//     reqN_i       in   1     access request from requester N
//     addrN_i      in   size  requester N address
//     wdataN_i     in   size  requester N write data
//     weN_i        in   1     requester N write enable
//     gntN_o       out  1     requester N owns the memory port (ACCESS)
//     doneN_o      out  1     one-cycle completion pulse for requester N
//     rdata_o      out  size  registered read data, held until next capture
//     mem_en_o     out  1     memory access strobe (high through ACCESS)
//     mem_we_o     out  1     memory write enable
//     mem_addr_o   out  size  memory address
//     mem_wdata_o  out  size  memory write data
//     mem_rdata_i  in   size  memory read data, valid in final ACCESS cycle
//     sel_o        out  1     current owner
//     busy_o       out  1     FSM is not in IDLE
module bus_arbiter_2to1
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int size = 32,
  parameter int LAT  = DEFAULT_LAT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  logic [size-1:0] addr0_i,
  input  logic [size-1:0] addr1_i,
  input  logic [size-1:0] wdata0_i,
  input  logic [size-1:0] wdata1_i,
  input  logic            we0_i,
  input  logic            we1_i,
  output logic            gnt0_o,
  output logic            gnt1_o,
  output logic            done0_o,
  output logic            done1_o,
  output logic [size-1:0] rdata_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [size-1:0] mem_addr_o,
  output logic [size-1:0] mem_wdata_o,
  input  logic [size-1:0] mem_rdata_i,
  output logic            sel_o,
  output logic            busy_o
);

  // ACCESS runs while cnt counts LAT-1 down to 0, i.e. LAT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sel_q;
  logic              last_q;
  logic [size-1:0]   rdata_q;

  // Output flags are registered alongside the state so every output is
  // a flop (or a mux steered only by flops), never a decode glitch.
  logic              gnt0_q;
  logic              gnt1_q;
  logic              done0_q;
  logic              done1_q;
  logic              mem_en_q;
  logic              busy_q;

  logic              winner;
  logic [0:0]        we_sel;

  assign winner = arb_winner(req0_i, req1_i, last_q);

  // ------------------------------------------------------------------
  // Requester-to-memory routing, steered by the registered owner.
  // ------------------------------------------------------------------
  MUX_2to1 #(.size(size)) u_addr_mux (
    .sel (sel_q),
    .in0 (addr0_i),
    .in1 (addr1_i),
    .out (mem_addr_o)
  );

  MUX_2to1 #(.size(size)) u_wdata_mux (
    .sel (sel_q),
    .in0 (wdata0_i),
    .in1 (wdata1_i),
    .out (mem_wdata_o)
  );

  MUX_2to1 #(.size(1)) u_we_mux (
    .sel (sel_q),
    .in0 (we0_i),
    .in1 (we1_i),
    .out (we_sel)
  );

  // ------------------------------------------------------------------
  // Arbitration FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;   // requester 0 wins the first tie
      rdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            state_q  <= ACCESS;
            cnt_q    <= CNT_LOAD;
            sel_q    <= winner;
            gnt0_q   <= ~winner;
            gnt1_q   <= winner;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        ACCESS: begin
          // Dropping req here is ignored: the access always completes.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Captured on writes as well; the content is simply unused.
            rdata_q  <= mem_rdata_i;
            last_q   <= sel_q;
            state_q  <= DONE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            mem_en_q <= 1'b0;
            done0_q  <= ~sel_q;
            done1_q  <= sel_q;
          end
        end

        DONE: begin
          // A request still high here is picked up again in IDLE.
          state_q <= IDLE;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          // Unused encoding: return to a clean IDLE.
          state_q  <= IDLE;
          cnt_q    <= '0;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          done0_q  <= 1'b0;
          done1_q  <= 1'b0;
          mem_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign gnt0_o   = gnt0_q;
  assign gnt1_o   = gnt1_q;
  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign rdata_o  = rdata_q;
  assign mem_en_o = mem_en_q;
  // mem_en_q is high exactly in ACCESS, so it gates the selected we.
  assign mem_we_o = we_sel[0] & mem_en_q;
  assign sel_o    = sel_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// tb_bus_arbiter_2to1
//   Directed bench for bus_arbiter_2to1: one LAT=2 instance for the main
//   scenarios and one LAT=1 instance for the short-latency case, both fed
//   from the same stimulus. Inputs change 1 time unit after a rising edge;
//   outputs are checked at that same point.
module tb_bus_arbiter_2to1;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        we0, we1;
  logic [31:0] mem_rdata;

  // LAT=2 instance outputs
  logic        gnt0, gnt1, done0, done1, mem_en, mem_we, sel, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;

  // LAT=1 instance outputs
  logic        gnt0_b, gnt1_b, done0_b, done1_b, mem_en_b, mem_we_b, sel_b, busy_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bus_arbiter_2to1 #(.size(32), .LAT(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .we0_i(we0), .we1_i(we1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .done0_o(done0), .done1_o(done1),
    .rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .sel_o(sel), .busy_o(busy)
  );

  bus_arbiter_2to1 #(.size(32), .LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .we0_i(we0), .we1_i(we1),
    .gnt0_o(gnt0_b), .gnt1_o(gnt1_b),
    .done0_o(done0_b), .done1_o(done1_b),
    .rdata_o(rdata_b),
    .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
    .mem_rdata_i(mem_rdata),
    .sel_o(sel_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset pulse placed mid-cycle, released before next edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_done", {done0, done1}, 2'b00);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_sel", sel, 1'b0);
    #2;
    rst = 1'b0;
  endtask

  int prev_done;

  initial begin
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0;
    wdata0 = 32'h0; wdata1 = 32'h0;
    we0 = 1'b0; we1 = 1'b0;
    mem_rdata = 32'h0;

    step();
    do_reset();

    // ---- single read from requester 0 ----
    req0 = 1'b1; addr0 = 32'h10; addr1 = 32'h99;
    step();
    check("t1_gnt0_c2", gnt0, 1'b1);
    check("t1_gnt1_c2", gnt1, 1'b0);
    check("t1_addr_c2", mem_addr, 32'h10);
    check("t1_en_c2", mem_en, 1'b1);
    check("t1_busy_c2", busy, 1'b1);
    check("t1_we_c2", mem_we, 1'b0);
    mem_rdata = 32'h0000_1111;
    step();
    check("t1_gnt0_c3", gnt0, 1'b1);
    check("t1_addr_c3", mem_addr, 32'h10);
    check("t1_en_c3", mem_en, 1'b1);
    check("t1_done0_c3", done0, 1'b0);
    mem_rdata = 32'hA5A5_0001;
    step();
    check("t1_done0_c4", done0, 1'b1);
    check("t1_done1_c4", done1, 1'b0);
    check("t1_gnt0_c4", gnt0, 1'b0);
    check("t1_en_c4", mem_en, 1'b0);
    check("t1_rdata_c4", rdata, 32'hA5A5_0001);
    req0 = 1'b0;
    mem_rdata = 32'h0000_2222;
    step();
    check("t1_busy_c5", busy, 1'b0);
    check("t1_done0_c5", done0, 1'b0);
    check("t1_rdata_hold", rdata, 32'hA5A5_0001);
    $display("txn read0 addr=%h rdata=%h", addr0, rdata);

    // ---- continuous contention: round-robin 0,1,0,1 ----
    step();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 32'h100; addr1 = 32'h200;
    prev_done = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_gnt0", gnt0, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("rr_gnt1", gnt1, (k % 2 == 1) ? 1'b1 : 1'b0);
      check("rr_addr", mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      step();
      step();
      check("rr_done0", done0, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("rr_done1", done1, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k > 0) check("rr_done_spacing", cyc - prev_done, 32'd4);
      prev_done = cyc;
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step();
      check("rr_idle_busy", busy, 1'b0);
      $display("txn rr k=%0d owner=%0d done_cycle=%0d", k, k % 2, prev_done);
    end

    // ---- write from requester 1 ----
    step();
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hDEAD_BEEF;
    addr0 = 32'h10; wdata0 = 32'h0000_1234; we0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("wr_mem_we", mem_we, 1'b1);
      check("wr_addr", mem_addr, 32'h20);
      check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("wr_gnt1", gnt1, 1'b1);
      check("wr_gnt0", gnt0, 1'b0);
      check("wr_sel", sel, 1'b1);
      check("wr_done0", done0, 1'b0);
    end
    step();
    check("wr_done1", done1, 1'b1);
    check("wr_done0_d", done0, 1'b0);
    check("wr_mem_we_d", mem_we, 1'b0);
    req1 = 1'b0; we1 = 1'b0;
    step();
    check("wr_idle", busy, 1'b0);
    $display("txn write1 addr=%h wdata=%h", addr1, wdata1);

    // ---- req0 dropped during first ACCESS cycle ----
    req0 = 1'b1; addr0 = 32'h44;
    step();
    check("drop_gnt0_a1", gnt0, 1'b1);
    req0 = 1'b0;
    step();
    check("drop_gnt0_a2", gnt0, 1'b1);
    step();
    check("drop_done0", done0, 1'b1);
    step();
    check("drop_idle", busy, 1'b0);
    step();
    check("drop_no_regrant", gnt0, 1'b0);
    check("drop_still_idle", busy, 1'b0);
    $display("txn drop0 addr=%h", addr0);

    // ---- reset in the middle of ACCESS ----
    req0 = 1'b1;
    step();
    check("mid_gnt0", gnt0, 1'b1);
    check("mid_rdata_nz", rdata, 32'h0000_2222);
    rst = 1'b1;
    #2;
    check("mid_busy", busy, 1'b0);
    check("mid_gnt0_r", gnt0, 1'b0);
    check("mid_rdata", rdata, 32'h0);
    check("mid_done0", done0, 1'b0);
    req1 = 1'b1;
    #2;
    rst = 1'b0;
    step();
    check("mid_tie_gnt0", gnt0, 1'b1);
    check("mid_tie_gnt1", gnt1, 1'b0);
    check("mid_no_done", done0, 1'b0);
    step();
    step();
    check("mid_done0_end", done0, 1'b1);
    req0 = 1'b0;   // req1 stays high through DONE
    step();
    check("mid_idle", busy, 1'b0);
    step();
    check("rearb_gnt1", gnt1, 1'b1);
    step();
    step();
    check("rearb_done1", done1, 1'b1);
    req1 = 1'b0;
    step();
    $display("txn midreset then tie owner=0 then owner=1");

    // ---- LAT=1 instance ----
    do_reset();
    req0 = 1'b1; addr0 = 32'h30;
    step();
    check("l1_gnt0", gnt0_b, 1'b1);
    check("l1_addr", mem_addr_b, 32'h30);
    step();
    check("l1_gnt0_off", gnt0_b, 1'b0);
    check("l1_done0", done0_b, 1'b1);
    req0 = 1'b0;
    step();
    check("l1_done0_off", done0_b, 1'b0);
    check("l1_idle", busy_b, 1'b0);
    $display("txn lat1 read0 addr=%h", addr0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
